// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: load-type encodings, responder state enum and load decode helper
package dmem_responder_pkg;
  localparam logic [2:0] LT_NONE = 3'd0;
  localparam logic [2:0] LT_LB   = 3'd1;
  localparam logic [2:0] LT_LH   = 3'd2;
  localparam logic [2:0] LT_LW   = 3'd3;
  localparam logic [2:0] LT_LBU  = 3'd4;
  localparam logic [2:0] LT_LHU  = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  function automatic logic is_load(input logic [2:0] t);
    return t >= LT_LB && t <= LT_LHU;
  endfunction
endpackage

// File: rtl/dmem_responder_ext.sv
// load_data_ext: selects byte/halfword/word lane of a read word and sign/zero-extends it
module load_data_ext
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  i_type,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_word,
  output logic [31:0] o_result
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
  always_comb
    o_result = i_type == LT_LB  ? {{24{w_byte[7]}}, w_byte} :
               i_type == LT_LBU ? {24'b0, w_byte} :
               i_type == LT_LH  ? {{16{w_half[15]}}, w_half} :
               i_type == LT_LHU ? {16'b0, w_half} :
               i_type == LT_LW  ? i_word : '0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage responder that stalls the pipeline while one load/store completes on backing memory
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        load_type_MEM,
  input  logic [3:0]        cache_write_en_MEM,
  input  logic [ADDR_W-1:0] addr_MEM,
  input  logic [31:0]       wdata_MEM,
  output logic              stall_mem,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_type;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata, r_load_data, w_ext;
  logic              w_store, w_access;
  assign w_store  = |cache_write_en_MEM;
  assign w_access = w_store | is_load(load_type_MEM);
  always_comb
    w_next = r_state == S_IDLE ? (w_access ? S_WAIT : S_IDLE) :
             r_state == S_WAIT ? (mem_ack ? S_DONE : S_WAIT) : S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  // a store wins over a simultaneous load, so the latched type becomes none
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr      <= '0;
      r_type      <= LT_NONE;
      r_be        <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
    end else begin
      if (r_state == S_IDLE && w_access) begin
        r_addr  <= addr_MEM;
        r_type  <= w_store ? LT_NONE : load_type_MEM;
        r_be    <= cache_write_en_MEM;
        r_wdata <= wdata_MEM << {addr_MEM[1:0], 3'b000};
      end
      if (r_state == S_WAIT && mem_ack && r_type != LT_NONE) r_load_data <= w_ext;
    end
  load_data_ext u_ext (
    .i_type  (r_type),
    .i_offset(r_addr[1:0]),
    .i_word  (mem_rdata),
    .o_result(w_ext)
  );
  assign stall_mem  = rst_n & ((r_state == S_IDLE & w_access) | r_state == S_WAIT);
  assign mem_req    = r_state == S_WAIT;
  assign mem_we     = mem_req & |r_be;
  assign mem_be     = mem_req ? r_be : 4'b0000;
  assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
  assign mem_wdata  = r_wdata;
  assign load_valid = r_state == S_DONE && r_type != LT_NONE;
  assign load_data  = r_load_data;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed accesses with a scoreboard queue checked by an independent bus/DONE monitor
module tb_dmem_responder;
  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ld;
    logic [31:0] ldata;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [2:0]  load_type_MEM = 3'd3;
  logic [3:0]  cache_write_en_MEM = 4'd0;
  logic [31:0] addr_MEM = 32'h104;
  logic [31:0] wdata_MEM = 32'h5555_5555;
  logic        stall_mem, load_valid, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 0;
  logic [31:0] mem_rdata = 0;

  exp_t        q[$];
  exp_t        e;
  int          n_chk = 0, n_fail = 0;
  int          ack_lat = 0, wcnt = 0;
  logic [31:0] rd_word = 0, last_ld = 0;
  logic        ack_force = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_type_MEM(load_type_MEM), .cache_write_en_MEM(cache_write_en_MEM),
    .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
    .stall_mem(stall_mem), .load_data(load_data), .load_valid(load_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // backing memory: acks after ack_lat extra WAIT cycles, or on a forced stray pulse
  always @(negedge clk) begin
    mem_ack = ack_force;
    if (mem_req) begin
      if (wcnt >= ack_lat) begin
        mem_ack = 1;
        mem_rdata = rd_word;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  always @(negedge clk) begin
    #1;
    if (mem_req) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_req: got request addr %h expected none", mem_addr);
      end else begin
        chk("mem_addr", mem_addr, q[0].addr);
        chk("mem_we", 32'(mem_we), 32'(q[0].we));
        chk("mem_be", 32'(mem_be), 32'(q[0].be));
        chk("mem_wdata", mem_wdata, q[0].wdata);
        if (mem_ack) begin
          e = q.pop_front();
          @(negedge clk);
          #1;
          chk("done_req", 32'(mem_req), 32'd0);
          chk("done_stall", 32'(stall_mem), 32'd0);
          chk("load_valid", 32'(load_valid), 32'(e.ld));
          chk("load_data", load_data, e.ld ? e.ldata : last_ld);
          if (e.ld) last_ld = e.ldata;
        end
      end
    end
  end

  task automatic issue(input logic [2:0] lt, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int lat,
                       input int exp_stall, input logic [31:0] ea, input logic [31:0] ew,
                       input logic ld, input logic [31:0] ldata);
    exp_t x;
    int n = 0;
    @(negedge clk);
    load_type_MEM = lt;
    cache_write_en_MEM = be;
    addr_MEM = a;
    wdata_MEM = wd;
    rd_word = rd;
    ack_lat = lat;
    if (exp_stall > 0) begin
      x.we = be != 4'b0000;
      x.be = be;
      x.addr = ea;
      x.wdata = ew;
      x.ld = ld;
      x.ldata = ldata;
      q.push_back(x);
    end
    #1;
    while (stall_mem && n < 40) begin
      if (n == 0) chk("idle_req", 32'(mem_req), 32'd0);
      else if (n == 1) chk("wait_req", 32'(mem_req), 32'd1);
      n++;
      @(negedge clk);
      #1;
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    load_type_MEM = 3'd0;
    cache_write_en_MEM = 4'd0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_lvalid", 32'(load_valid), 32'd0);
    load_type_MEM = 3'd0;
    @(negedge clk);
    rst_n = 1;
    issue(3'd1, 4'b0000, 32'h103, 32'h0,         32'h80FF_1234, 0, 2, 32'h100, 32'h0,         1, 32'hFFFF_FF80);
    issue(3'd5, 4'b0000, 32'h102, 32'h0,         32'h9ABC_5678, 2, 4, 32'h100, 32'h0,         1, 32'h0000_9ABC);
    issue(3'd0, 4'b0100, 32'h202, 32'h0000_00AA, 32'h0,         0, 2, 32'h200, 32'h00AA_0000, 0, 32'h0);
    issue(3'd3, 4'b1111, 32'h300, 32'hDEAD_BEEF, 32'h1234_5678, 1, 3, 32'h300, 32'hDEAD_BEEF, 0, 32'h0);
    issue(3'd6, 4'b0000, 32'h400, 32'h0,         32'h0,         0, 0, 32'h0,   32'h0,         0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("none_req", 32'(mem_req), 32'd0);
    end
    issue(3'd2, 4'b0000, 32'h002, 32'h0,         32'h8001_7FFF, 0, 2, 32'h0,   32'h0,         1, 32'hFFFF_8001);
    issue(3'd2, 4'b0000, 32'h001, 32'h0,         32'h1234_8765, 0, 2, 32'h0,   32'h0,         1, 32'hFFFF_8765);
    issue(3'd4, 4'b0000, 32'h001, 32'h0,         32'h0000_F000, 1, 3, 32'h0,   32'h0,         1, 32'h0000_00F0);
    issue(3'd0, 4'b1000, 32'h003, 32'h0000_BEEF, 32'h0,         0, 2, 32'h0,   32'hEF00_0000, 0, 32'h0);
    issue(3'd3, 4'b0000, 32'h010, 32'h0,         32'h1122_3344, 0, 2, 32'h10,  32'h0,         1, 32'h1122_3344);
    issue(3'd3, 4'b0000, 32'h014, 32'h0,         32'h5566_7788, 0, 2, 32'h14,  32'h0,         1, 32'h5566_7788);
    @(negedge clk);
    load_type_MEM = 3'd3;
    addr_MEM = 32'h40;
    ack_lat = 100;
    e.we = 0; e.be = 0; e.addr = 32'h40; e.wdata = 32'h0; e.ld = 1; e.ldata = 0;
    q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("wrst_req", 32'(mem_req), 32'd0);
    chk("wrst_stall", 32'(stall_mem), 32'd0);
    chk("wrst_lvalid", 32'(load_valid), 32'd0);
    chk("wrst_addr", mem_addr, 32'd0);
    chk("wrst_ldata", load_data, 32'd0);
    q.delete();
    last_ld = 0;
    load_type_MEM = 3'd0;
    @(negedge clk);
    rst_n = 1;
    #2;
    ack_force = 1;
    @(negedge clk);
    #2;
    ack_force = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("late_ack_req", 32'(mem_req), 32'd0);
      chk("late_ack_lvalid", 32'(load_valid), 32'd0);
    end
    issue(3'd3, 4'b0000, 32'h020, 32'h0,         32'hCAFE_F00D, 0, 2, 32'h20,  32'h0,         1, 32'hCAFE_F00D);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port load_type_MEM  in  3  load type from EX/MEM control register: 0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 6/7 treated as none.
REQ-005 SHALL have port cache_write_en_MEM  in  4  store byte enables, already lane-aligned; nonzero marks a store.
REQ-006 SHALL have port addr_MEM  in  ADDR_W  byte address of the access.
REQ-007 SHALL have port wdata_MEM  in  32  unshifted store data.
REQ-008 SHALL have port stall_mem  out  1  hold request to hazard unit (bubble upstream segment registers).
REQ-009 SHALL have port load_data  out  32  extended load result.
REQ-010 SHALL have port load_valid  out  1  load_data valid this cycle.
REQ-011 SHALL have port mem_req  out  1  backing-memory request.
REQ-012 SHALL have port mem_we  out  1  1 = write.
REQ-013 SHALL have port mem_be  out  4  write byte strobes.
REQ-014 SHALL have port mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
REQ-015 SHALL have port mem_wdata  out  32  lane-shifted store data.
REQ-016 SHALL have port mem_ack  in  1  request completed; rdata valid same cycle.
REQ-017 SHALL have port mem_rdata  in  32  read word.

Function
REQ-018 SHALL implement states IDLE, WAIT, DONE.
REQ-019 Access present = store (cache_write_en_MEM != 0) or load (load_type_MEM in 1..5); store SHALL take priority if both, load ignored.
REQ-020 In IDLE with access present: stall_mem SHALL be 1 combinationally; at the edge, latch addr, type, be, shifted wdata; go WAIT.
REQ-021 mem_wdata SHALL equal wdata_MEM << (8*addr[1:0]), truncated to 32 bits.
REQ-022 In WAIT: mem_req=1, stall_mem=1; mem_req, mem_we, mem_be, mem_addr, mem_wdata SHALL be stable until mem_ack.
REQ-023 WAIT with mem_ack=1 SHALL go DONE, registering extended load_data for loads.
REQ-024 In DONE: stall_mem=0, mem_req=0, load_valid=1 for loads (0 for stores); inputs ignored (still the completed instruction); next state IDLE.
REQ-025 Minimum access latency: 3 cycles (IDLE, WAIT with same-cycle ack, DONE); stall_mem high exactly 1 + WAIT cycles.
REQ-026 Extension: LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1], addr[0] ignored; LW full word; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-027 mem_ack outside WAIT SHALL be ignored.
REQ-028 load_data SHALL hold its last value when load_valid=0.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, load_data=0, load_valid=0, stall_mem=0 regardless of inputs.
REQ-030 Reset during WAIT SHALL abandon the access; a late mem_ack after reset SHALL be ignored.

Structure
REQ-031 Load-type constants and the state enum SHALL reside in the shared core package.
REQ-032 Extension logic SHALL be a combinational sub-module load_data_ext (inputs type, offset, word; output 32-bit result).

Verification
REQ-033 LB at addr 0x103, mem_rdata 0x80FF_1234, ack in 1st WAIT cycle -> stall 2 cycles, DONE load_data 0xFFFF_FF80, load_valid 1.
REQ-034 LHU at 0x102, rdata 0x9ABC_5678, ack after 3 WAIT cycles -> stall 4 cycles, load_data 0x0000_9ABC, mem_addr 0x100 held stable.
REQ-035 SB be 4'b0100, wdata 0x0000_00AA, addr 0x202 -> mem_we 1, mem_be 4'b0100, mem_wdata 0x00AA_0000, load_valid 0 in DONE.
REQ-036 load_type 3 with be 4'b1111 simultaneously -> write performed, no load_valid; load_type 6 alone -> no request, stall 0.
REQ-037 rst_n low in 2nd WAIT cycle, then mem_ack pulse -> mem_req 0 immediately, state IDLE, no load_valid.
REQ-038 Back-to-back LW 0x10 then LW 0x14 -> second request enters WAIT one cycle after first DONE, no duplicate access of 0x10.
